// File: rtl/uart_rx_buffer_pkg.sv
// uart_rx_buffer_pkg: entry layout and interrupt source indices for the receive buffer
package uart_rx_buffer_pkg;
    localparam int ENT_PERR = 8;
    localparam int ENT_FERR = 9;
    localparam int ENT_W    = 10;
    localparam int IRQ_THR  = 0;
    localparam int IRQ_TMO  = 1;
    localparam int IRQ_OVR  = 2;

    function automatic logic [ENT_W-1:0] pack_entry(input logic [7:0] d, input logic perr, input logic ferr);
        logic [ENT_W-1:0] e;
        e           = {2'b00, d};
        e[ENT_PERR] = perr;
        e[ENT_FERR] = ferr;
        return e;
    endfunction
endpackage

// File: rtl/uart_rx_buffer_mem.sv
// uart_rx_buffer_mem: simple dual-port entry array, synchronous write, asynchronous head read
module uart_rx_buffer_mem
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [ENT_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [ENT_W-1:0] rdata
);
    logic [ENT_W-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
    end

    assign rdata = ram[raddr];
endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: FWFT receive FIFO with overrun, threshold, idle timeout and level interrupt
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int          DEPTH          = 64,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd10000,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    data,
    input  logic          newData,
    input  logic          error_parity,
    input  logic          error_frame,
    input  logic          rd_en,
    input  logic          flush,
    input  logic          clr_overrun,
    input  logic [CW-1:0] threshold,
    input  logic [2:0]    irq_mask,
    output logic [7:0]    rd_data,
    output logic          rd_parity_err,
    output logic          rd_frame_err,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overrun,
    output logic          timeout,
    output logic          interrupt
);
    logic             nd_q, overrun_q, overrun_d, timeout_q, timeout_d, irq_q, irq_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      tcnt_q, tcnt_d;
    logic             push, pop, wr, ovf, act;
    logic [ENT_W-1:0] head;

    uart_rx_buffer_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr),
        .waddr (wr_ptr_q),
        .wdata (pack_entry(data, error_parity, error_frame)),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        push      = newData & ~nd_q;
        pop       = rd_en & ~empty & ~flush;
        wr        = push & ~flush & (~full | pop);
        ovf       = push & ~flush & full & ~pop;
        act       = push | pop | flush;
        wr_ptr_d  = flush ? '0 : wr_ptr_q + AW'(wr);
        rd_ptr_d  = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d   = flush ? '0 : count_q + CW'(wr) - CW'(pop);
        overrun_d = ~flush & (ovf | (overrun_q & ~clr_overrun));
        tcnt_d    = (act | empty) ? '0 : (tcnt_q == TIMEOUT_CYCLES ? tcnt_q : tcnt_q + 16'd1);
        timeout_d = ~act & (timeout_q | (~empty & tcnt_q == TIMEOUT_CYCLES - 16'd1));
        irq_d     = (irq_mask[IRQ_THR] & threshold != '0 & count_q >= threshold)
                  | (irq_mask[IRQ_TMO] & timeout_q)
                  | (irq_mask[IRQ_OVR] & overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nd_q      <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            nd_q      <= newData;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            tcnt_q    <= tcnt_d;
            irq_q     <= irq_d;
        end
    end

    // Head is forced to zero when empty so no stale entry is ever presented
    assign {rd_frame_err, rd_parity_err, rd_data} = empty ? '0 : head;
    assign empty     = count_q == '0;
    assign full      = count_q == CW'(DEPTH);
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;
    assign interrupt = irq_q;
endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side buffer placed directly downstream of `uart_rx`. It captures each received character together with its parity and frame error flags into a circular FIFO, and exposes a first-word-fall-through pop port to the bus/register layer. It also provides overrun detection, a fill-level threshold, and an idle-character timeout, and combines these into a single level interrupt. It is the receive counterpart of the transmit buffer in the `uart_tx` IP.

## Interface
- `DEPTH`, 64: FIFO entries; must be a power of two, at least 2.
- `TIMEOUT_CYCLES`, 16'd10000: clk cycles with no push or pop, while the FIFO is non-empty, before the timeout flag sets.
- `clk`  in  1: system clock. One clock domain only.
- `rst`  in  1: synchronous, active-high reset.
- `data`  in  8: received character from `uart_rx`. Sampled on a `newData` rising edge.
- `newData`  in  1: new-character indication from `uart_rx`. May stay high for more than one cycle. Only the rising edge counts.
- `error_parity`, `error_frame`  in  1 each: error flags for the character, sampled together with `data`.
- `rd_en`  in  1: pop request. Ignored when `empty`.
- `flush`  in  1: discard all entries and clear the overrun and timeout flags.
- `clr_overrun`  in  1: clear the sticky overrun flag.
- `threshold`  in  clog2(DEPTH+1): fill level for the threshold interrupt. A value of 0 disables it.
- `irq_mask`  in  3: per-source enable. Bit 0 = threshold, bit 1 = timeout, bit 2 = overrun.
- `rd_data`  out  8: character at the head of the FIFO.
- `rd_parity_err`, `rd_frame_err`  out  1 each: error flags stored with the head entry.
- `empty`, `full`  out  1 each: FIFO status.
- `count`  out  clog2(DEPTH+1): number of stored entries.
- `overrun`, `timeout`  out  1 each: sticky status flags.
- `interrupt`  out  1: registered level interrupt.

## Operation
- **Edge detect:** register `newData` into `nd_q`. Push request = `newData & ~nd_q`.
- **Entry format:** 10 bits. Bits [7:0] = data, bit 8 = parity error, bit 9 = frame error.
- **Pointers:** write and read pointers are clog2(DEPTH) bits wide and wrap naturally. `count` is tracked separately. `full` = (count == DEPTH). `empty` = (count == 0).
- **Priority, highest first:**
  - `rst`: clears all state.
  - `flush`: sets pointers and count to 0 and clears `overrun` and `timeout`. Any push in the same cycle is dropped.
  - Normal push/pop.
- **Push while not full:** write the entry and increment the write pointer.
- **Push while full:**
  - With a valid pop in the same cycle, both happen and `count` is unchanged.
  - Otherwise the character is dropped and `overrun` sets.
- **Pop while not empty:** increment the read pointer.
- **Push and pop while empty:** only the push happens. The new entry is visible on `rd_data` the next cycle.
- **Overrun clear:** `overrun` stays set until `clr_overrun` or `flush`. If `clr_overrun` coincides with a new overrun event, the flag remains set.
- **Timeout counter:**
  - Resets to 0 on any push, pop, flush, or while empty.
  - Otherwise increments, saturating at `TIMEOUT_CYCLES`.
  - On reaching `TIMEOUT_CYCLES - 1`, `timeout` sets.
  - `timeout` clears on a pop, a flush, or a push.
- **Interrupt:** `interrupt` is registered from (`irq_mask[0]` & threshold≠0 & count ≥ threshold) | (`irq_mask[1]` & `timeout`) | (`irq_mask[2]` & `overrun`).

## Timing
- **Reset values:** `count`=0, `empty`=1, `full`=0, `overrun`=0, `timeout`=0, `interrupt`=0, `rd_data`=0, `rd_*_err`=0, `nd_q`=0.
- **Push latency:** the push is detected in the cycle where `newData` is high and `nd_q` is low. `count`, `empty` and `rd_data` (if the FIFO was empty) update on the next clk edge.
- **Pop:** FWFT. The head is valid whenever `empty`=0. The next entry appears on `rd_data` one cycle after the `rd_en` edge.
- **Status flags:** `count`, `full`, `empty` are registered and consistent with each other every cycle.
- **Interrupt latency:** `interrupt` lags its source condition by exactly 1 cycle.
- **Reset or flush mid-operation:** takes effect on the next edge. No stale entry may be popped afterwards.

## Structure
- **Package `uart_rx_buffer_pkg`:**
  - entry bit positions (`ENT_PERR`=8, `ENT_FERR`=9, `ENT_W`=10);
  - irq mask bit indices.
- **Sub-module `uart_rx_buffer_mem`:**
  - DEPTH×ENT_W simple dual-port array;
  - synchronous write, asynchronous read of the head entry (FWFT);
  - inferable as distributed RAM.
- **Top module:** pointers, count, flags, timeout counter, interrupt.

## Test plan
- **Single character:** pulse `newData` with `data`=8'hAA and no errors → after 1 cycle: `empty`=0, `count`=1, `rd_data`=8'hAA. Pop → `empty`=1.
- **Long newData:** hold `newData` high for 5 cycles → exactly one entry is stored.
- **Fill and overrun:** push 0..67 with DEPTH=64 →
  - `full` after the 64th push;
  - 4 drops and `overrun`=1;
  - popping yields 0..63 in order;
  - `clr_overrun` → `overrun`=0.
- **Error flags:** push 8'h55 with `error_parity`=1, then 8'h66 with `error_frame`=1 → the head shows `rd_parity_err`=1; after one pop, `rd_frame_err`=1 and `rd_parity_err`=0.
- **Threshold and timeout:** with `threshold`=4 and `irq_mask`=3'b011:
  - push 3 → `interrupt`=0; the 4th push → `interrupt`=1 one cycle later;
  - pop to 1 entry and wait `TIMEOUT_CYCLES` → `timeout`=1 and `interrupt`=1;
  - pop → both clear.
- **Simultaneous events:**
  - push with `full` and `rd_en` → `count` stays 64 and `overrun`=0;
  - `flush` with a push → `count`=0 and `empty`=1.
